// File: rtl/bpm_pkg.sv
// Shared types and constants for the BPM tracker controller and its divider.
package bpm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_UPDATE = 2'd3
    } bpm_state_t;

    localparam int MS_PER_MIN = 60000;
    localparam int DIV_W      = 16;

    // Shortest interval (ms) still accepted for the fastest allowed tempo.
    function automatic int min_interval_ms(input int max_bpm);
        return MS_PER_MIN / max_bpm;
    endfunction

    // Longest interval (ms) still accepted for the slowest allowed tempo.
    function automatic int max_interval_ms(input int min_bpm);
        return MS_PER_MIN / min_bpm;
    endfunction

endpackage

// File: rtl/bpm_tracker_ctrl_if.sv
// Beat-in / BPM-out bundle between the beat detector, the tracker and its consumers.
interface bpm_tracker_ctrl_if #(
    parameter int BPM_WIDTH = 16
);
    logic                 enable;
    logic                 beat_pulse;
    logic [BPM_WIDTH-1:0] bpm_val;
    logic                 bpm_valid;
    logic                 beat_rejected;
    logic                 locked;
    logic [15:0]          interval_ms;

    // Side that drives run control and beats, and consumes the BPM result.
    modport master (
        output enable, beat_pulse,
        input  bpm_val, bpm_valid, beat_rejected, locked, interval_ms
    );

    // The tracker itself.
    modport slave (
        input  enable, beat_pulse,
        output bpm_val, bpm_valid, beat_rejected, locked, interval_ms
    );
endinterface

// File: rtl/bpm_div_seq.sv
// 16-bit restoring divider: one quotient bit per clock, done pulses 16 clocks
// after start is sampled. A new start simply restarts the division.
module bpm_div_seq
    import bpm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W:0]   rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [4:0]       steps_q;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   trial;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        shifted = {rem_q[DIV_W-1:0], quo_q[DIV_W-1]};
        trial   = shifted - {1'b0, divisor};
    end

    // Load on start, then shift in one quotient bit per cycle until steps run out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            steps_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q   <= '0;
                quo_q   <= dividend;
                steps_q <= 5'(DIV_W);
            end else if (steps_q != 5'd0) begin
                if (!trial[DIV_W]) begin
                    rem_q <= trial;
                    quo_q <= {quo_q[DIV_W-2:0], 1'b1};
                end else begin
                    rem_q <= shifted;
                    quo_q <= {quo_q[DIV_W-2:0], 1'b0};
                end
                steps_q <= steps_q - 5'd1;
                done    <= (steps_q == 5'd1);
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/bpm_tracker_ctrl.sv
// BPM tracker controller: times beat intervals in ms, rejects refractory and
// out-of-range beats, divides 60000 by the interval and publishes the BPM with
// lock and timeout status.
// Optional build macro BPM_AVG_EN: publish the mean of the last 4 quotients
// (one extra cycle of latency).
//
// state  | meaning
// IDLE   | not timing; first beat starts the reference
// ARMED  | timing the interval since the last reference beat
// DIVIDE | divider running on the latched interval
// UPDATE | result published this cycle, back to ARMED next
module bpm_tracker_ctrl
    import bpm_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BPM_WIDTH  = 16,
    parameter int MIN_BPM    = 40,
    parameter int MAX_BPM    = 240,
    parameter int REFRACT_MS = 200,
    parameter int TIMEOUT_MS = 3000
)(
    input  logic               clk,
    input  logic               reset,
    bpm_tracker_ctrl_if.slave  bus
);

    localparam int              CLKS_PER_MS = CLOCK_FREQ / 1000;
    localparam int              PW          = $clog2(CLKS_PER_MS);
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLKS_PER_MS - 1);
    localparam logic [15:0]     IV_LO       = 16'(min_interval_ms(MAX_BPM));
    localparam logic [15:0]     IV_HI       = 16'(max_interval_ms(MIN_BPM));
    localparam logic [15:0]     IV_REF      = 16'(REFRACT_MS);
    localparam logic [15:0]     IV_TO       = 16'(TIMEOUT_MS);

    bpm_state_t           state_q, state_d;
    logic [PW-1:0]        presc_q;
    logic [15:0]          ival_q;
    logic [15:0]          ival_out_q;
    logic [DIV_W-1:0]     divisor_q;
    logic                 div_start_q;
    logic                 div_done;
    logic [DIV_W-1:0]     div_quo;
    logic [1:0]           lock_cnt_q;
    logic [BPM_WIDTH-1:0] bpm_val_q;
    logic                 bpm_valid_q;
    logic                 rej_q;
    logic                 ms_tick;
    logic                 res_ready;
    logic [BPM_WIDTH-1:0] res_val;

    logic restart, accept, reject, publish, timeout, lock_clr, cnt_clr;

    assign ms_tick = (state_q != ST_IDLE) && (presc_q == PRESC_LAST);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle decisions; timeout outranks a same-cycle beat.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        accept   = 1'b0;
        reject   = 1'b0;
        publish  = 1'b0;
        timeout  = 1'b0;
        lock_clr = 1'b0;
        cnt_clr  = 1'b0;
        if (!bus.enable) begin
            state_d  = ST_IDLE;
            lock_clr = 1'b1;
            cnt_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.beat_pulse) begin
                        restart = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (ival_q >= IV_TO) begin
                        timeout  = 1'b1;
                        lock_clr = 1'b1;
                        cnt_clr  = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (bus.beat_pulse) begin
                        if (ival_q < IV_REF) begin
                            reject = 1'b1;
                        end else if ((ival_q < IV_LO) || (ival_q > IV_HI)) begin
                            reject   = 1'b1;
                            lock_clr = 1'b1;
                            restart  = 1'b1;
                        end else begin
                            accept  = 1'b1;
                            restart = 1'b1;
                            state_d = ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    reject = bus.beat_pulse;
                    if (res_ready) begin
                        publish = 1'b1;
                        state_d = ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    reject  = bus.beat_pulse;
                    state_d = ST_ARMED;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Millisecond prescaler and saturating interval counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            ival_q  <= '0;
        end else if (cnt_clr || restart) begin
            presc_q <= '0;
            ival_q  <= '0;
        end else if (state_q != ST_IDLE) begin
            if (ms_tick) begin
                presc_q <= '0;
                if (ival_q < IV_TO) ival_q <= ival_q + 16'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Output registers, divider launch and lock counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bpm_val_q   <= '0;
            bpm_valid_q <= 1'b0;
            rej_q       <= 1'b0;
            div_start_q <= 1'b0;
            divisor_q   <= '0;
            ival_out_q  <= '0;
            lock_cnt_q  <= '0;
        end else begin
            bpm_valid_q <= publish || timeout;
            rej_q       <= reject;
            div_start_q <= accept;
            if (accept) begin
                divisor_q  <= ival_q;
                ival_out_q <= ival_q;
            end
            if (publish)      bpm_val_q <= res_val;
            else if (timeout) bpm_val_q <= '0;
            if (lock_clr)
                lock_cnt_q <= '0;
            else if (publish && (lock_cnt_q != 2'd2))
                lock_cnt_q <= lock_cnt_q + 2'd1;
        end
    end

    bpm_div_seq u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_q),
        .dividend (16'(MS_PER_MIN)),
        .divisor  (divisor_q),
        .done     (div_done),
        .quotient (div_quo)
    );

`ifdef BPM_AVG_EN
    logic [DIV_W-1:0] hist_q [4];
    logic             hist_first_q;
    logic             done_d_q;
    logic             hist_load;
    logic [DIV_W+1:0] hist_sum;

    assign hist_load = div_done && (state_q == ST_DIVIDE) && bus.enable;

    // Sum of the four most recent quotients.
    always_comb begin
        hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
                 + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    end

    // Quotient history; the first result after IDLE fills all entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            hist_first_q <= 1'b1;
            done_d_q     <= 1'b0;
        end else begin
            done_d_q <= hist_load;
            if (state_q == ST_IDLE) begin
                hist_first_q <= 1'b1;
            end else if (hist_load) begin
                hist_first_q <= 1'b0;
                if (hist_first_q) begin
                    for (int i = 0; i < 4; i++) hist_q[i] <= div_quo;
                end else begin
                    hist_q[0] <= div_quo;
                    hist_q[1] <= hist_q[0];
                    hist_q[2] <= hist_q[1];
                    hist_q[3] <= hist_q[2];
                end
            end
        end
    end

    assign res_ready = done_d_q;
    assign res_val   = BPM_WIDTH'(hist_sum >> 2);
`else
    assign res_ready = div_done;
    assign res_val   = BPM_WIDTH'(div_quo);
`endif

    assign bus.bpm_val       = bpm_val_q;
    assign bus.bpm_valid     = bpm_valid_q;
    assign bus.beat_rejected = rej_q;
    assign bus.locked        = (lock_cnt_q == 2'd2);
    assign bus.interval_ms   = ival_out_q;

endmodule
